// File: rtl/rbi_l2_mmio_bridge.sv
// L2 ring node that turns ring requests in the 0xF000_0000 MMIO window into single
// accesses on a 64-bit MMIO port, then injects the response into the next empty slot.
module rbi_l2_mmio_bridge #(
  parameter int MMIO_TIMEOUT = 4095
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [47:0]  memAddrIn,
  output logic [47:0]  memAddrOut,
  input  logic [127:0] memDataIn,
  output logic [127:0] memDataOut,
  input  logic [15:0]  memOpmIn,
  output logic [15:0]  memOpmOut,
  input  logic [15:0]  memSeqIn,
  output logic [15:0]  memSeqOut,
  input  logic [7:0]   unitNodeId,
  output logic [31:0]  mmioAddr,
  output logic [4:0]   mmioOpm,
  input  logic [63:0]  mmioInData,
  output logic [63:0]  mmioOutData,
  input  logic [1:0]   mmioOK
);

  localparam int CNT_W = (MMIO_TIMEOUT < 2) ? 1 : $clog2(MMIO_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MMIO_TIMEOUT - 1);

  localparam logic [1:0] OK_READY = 2'b00;
  localparam logic [1:0] OK_DONE  = 2'b01;
  localparam logic [1:0] OK_FAULT = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RELEASE = 2'd2,
    RESPOND = 2'd3
  } bridgeState_t;

  bridgeState_t state, nextState;

  logic [47:0]      reqAddr;
  logic [15:0]      reqOpm;
  logic [15:0]      reqSeq;
  logic [63:0]      reqData;
  logic [63:0]      readData;
  logic             fault;
  logic [CNT_W-1:0] waitCnt;

  logic isHit, slotEmpty, timeoutHit, reqIsStore, accept, inject;

  // The node ID is carried for debug visibility only; decode is purely address based.
  logic unusedNodeId;
  assign unusedNodeId = ^unitNodeId;

  assign isHit      = memOpmIn[7] && (memAddrIn[47:32] == 16'h0) && (memAddrIn[31:28] == 4'hF);
  assign slotEmpty  = (memOpmIn[7:0] == 8'h00);
  assign timeoutHit = (waitCnt == TIMEOUT_LAST);
  assign reqIsStore = reqOpm[6];

  assign mmioAddr    = reqAddr[31:0];
  assign mmioOutData = reqData;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    nextState = state;
    accept    = 1'b0;
    inject    = 1'b0;
    mmioOpm   = 5'd0;
    unique case (state)
      IDLE: begin
        if (isHit) begin
          accept    = 1'b1;
          nextState = ACCESS;
        end
      end
      ACCESS: begin
        mmioOpm = {(reqIsStore ? 2'b10 : 2'b01), reqOpm[2:0]};
        if (mmioOK == OK_DONE || mmioOK == OK_FAULT || timeoutHit) nextState = RELEASE;
      end
      RELEASE: begin
        if (mmioOK == OK_READY || timeoutHit) nextState = RESPOND;
      end
      RESPOND: begin
        if (slotEmpty) begin
          inject    = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so all flops update from
  // the same pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: the request latches are cleared too, so a reset mid-access leaves
      // nothing behind that could later surface as a stray response.
      reqAddr    <= '0;
      reqOpm     <= '0;
      reqSeq     <= '0;
      reqData    <= '0;
      readData   <= '0;
      fault      <= 1'b0;
      waitCnt    <= '0;
      memAddrOut <= '0;
      memDataOut <= '0;
      memOpmOut  <= '0;
      memSeqOut  <= '0;
    end else begin
      if (accept) begin
        reqAddr  <= memAddrIn;
        reqOpm   <= memOpmIn;
        reqSeq   <= memSeqIn;
        reqData  <= memDataIn[63:0];
        readData <= '0;
        fault    <= 1'b0;
      end

      if (state == ACCESS) begin
        if (mmioOK == OK_DONE) begin
          readData <= reqIsStore ? 64'h0 : mmioInData;
          fault    <= 1'b0;
        end else if (mmioOK == OK_FAULT || timeoutHit) begin
          fault <= 1'b1;
        end
      end

      // One counter serves both wait phases; it restarts on every state change.
      if (state != nextState)
        waitCnt <= '0;
      else if (state == ACCESS || state == RELEASE)
        waitCnt <= waitCnt + CNT_W'(1);

      if (accept) begin
        memAddrOut <= '0;
        memDataOut <= '0;
        memOpmOut  <= '0;
        memSeqOut  <= '0;
      end else if (inject) begin
        memAddrOut <= reqAddr;
        memDataOut <= {64'h0, (fault ? 64'h0 : readData)};
        memOpmOut  <= {reqOpm[15:8], 2'b01, (fault ? 6'h3F : reqOpm[5:0])};
        memSeqOut  <= reqSeq;
      end else begin
        memAddrOut <= memAddrIn;
        memDataOut <= memDataIn;
        memOpmOut  <= memOpmIn;
        memSeqOut  <= memSeqIn;
      end
    end
  end

endmodule

// File: tb/tb_rbi_l2_mmio_bridge.sv
// Directed bench for rbi_l2_mmio_bridge: a transaction-level model predicts every ring
// slot and MMIO request; literal checks pin the model on the key scenarios.
module tb_rbi_l2_mmio_bridge;

  localparam int TIMEOUT = 4095;

  typedef struct packed {
    logic [47:0]  addr;
    logic [127:0] data;
    logic [15:0]  opm;
    logic [15:0]  seq;
  } slot_t;

  logic         clock = 1'b0;
  logic         reset;
  logic [47:0]  memAddrIn  = '0;
  logic [127:0] memDataIn  = '0;
  logic [15:0]  memOpmIn   = '0;
  logic [15:0]  memSeqIn   = '0;
  logic [7:0]   unitNodeId = 8'h21;
  logic [63:0]  mmioInData = '0;
  logic [1:0]   mmioOK     = 2'b00;
  logic [47:0]  memAddrOut;
  logic [127:0] memDataOut;
  logic [15:0]  memOpmOut;
  logic [15:0]  memSeqOut;
  logic [31:0]  mmioAddr;
  logic [4:0]   mmioOpm;
  logic [63:0]  mmioOutData;

  rbi_l2_mmio_bridge #(.MMIO_TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .memAddrIn(memAddrIn), .memAddrOut(memAddrOut),
    .memDataIn(memDataIn), .memDataOut(memDataOut),
    .memOpmIn(memOpmIn), .memOpmOut(memOpmOut),
    .memSeqIn(memSeqIn), .memSeqOut(memSeqOut),
    .unitNodeId(unitNodeId),
    .mmioAddr(mmioAddr), .mmioOpm(mmioOpm),
    .mmioInData(mmioInData), .mmioOutData(mmioOutData),
    .mmioOK(mmioOK)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic slot_t mkSlot(input logic [47:0] a, input logic [127:0] d,
                                   input logic [15:0] o, input logic [15:0] s);
    slot_t r;
    r.addr = a; r.data = d; r.opm = o; r.seq = s;
    return r;
  endfunction

  function automatic slot_t dutOut();
    return mkSlot(memAddrOut, memDataOut, memOpmOut, memSeqOut);
  endfunction

  // ---------------- transaction-level reference model ----------------
  slot_t       expOut;
  slot_t       req;
  slot_t       curIn;
  bit          busy, issuing, draining, respPending, mFault;
  int          waitCnt;
  logic [63:0] result;

  function automatic bit mmioHit(input slot_t s);
    return (s.opm[7:6] == 2'b10 || s.opm[7:6] == 2'b11) && s.addr[47:28] == 20'h0000F;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      expOut = '0; req = '0; busy = 0; issuing = 0; draining = 0;
      respPending = 0; mFault = 0; waitCnt = 0; result = '0;
    end else begin
      curIn  = mkSlot(memAddrIn, memDataIn, memOpmIn, memSeqIn);
      expOut = curIn;
      if (issuing) begin
        if (mmioOK == 2'b01) begin
          result = (req.opm[7:6] == 2'b10) ? mmioInData : 64'h0;
          mFault = 0;
        end else if (mmioOK == 2'b11 || waitCnt + 1 >= TIMEOUT) begin
          result = 64'h0;
          mFault = 1;
        end
        if (mmioOK == 2'b01 || mmioOK == 2'b11 || waitCnt + 1 >= TIMEOUT) begin
          issuing = 0; draining = 1; waitCnt = 0;
        end else waitCnt++;
      end else if (draining) begin
        if (mmioOK == 2'b00 || waitCnt + 1 >= TIMEOUT) begin
          draining = 0; respPending = 1;
        end else waitCnt++;
      end else if (respPending) begin
        if (curIn.opm[7:0] == 8'h00) begin
          expOut = mkSlot(req.addr, {64'h0, mFault ? 64'h0 : result},
                          {req.opm[15:8], 2'b01, mFault ? 6'h3F : req.opm[5:0]}, req.seq);
          respPending = 0; busy = 0;
        end
      end else if (!busy && mmioHit(curIn)) begin
        req = curIn; expOut = '0; busy = 1; issuing = 1; waitCnt = 0;
      end
    end
  end

  // Compare process: ring slot and MMIO request every cycle.
  always @(negedge clock) begin
    check("ring slot", 256'(dutOut()), 256'(expOut));
    check("mmioOpm", 256'(mmioOpm),
          issuing ? 256'({(req.opm[6] ? 2'b10 : 2'b01), req.opm[2:0]}) : 256'(0));
    if (issuing) begin
      check("mmioAddr", 256'(mmioAddr), 256'(req.addr[31:0]));
      check("mmioOutData", 256'(mmioOutData), 256'(req.data[63:0]));
    end
  end

  // Response monitor.
  int respCount = 0;
  always @(negedge clock) if (reset && memOpmOut[7:6] == 2'b01) respCount++;

  // MMIO target: completes respDelay cycles after a request appears.
  int          respDelay   = 3;
  logic [1:0]  respCode    = 2'b01;
  logic [63:0] respData    = '0;
  bit          releaseBusy = 0;
  initial begin
    int holdCnt = 0;
    forever begin
      @(negedge clock);
      if (mmioOpm[4:3] != 2'b00) begin
        if (holdCnt >= respDelay) begin
          mmioOK     = respCode;
          mmioInData = respData;
        end else mmioOK = 2'b00;
        holdCnt++;
      end else begin
        holdCnt = 0;
        mmioOK  = releaseBusy ? 2'b10 : 2'b00;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic sendSlot(input slot_t s);
    memAddrIn = s.addr; memDataIn = s.data; memOpmIn = s.opm; memSeqIn = s.seq;
    @(posedge clock);
    #1;
  endtask

  task automatic waitResp(input int budget, input string name, output slot_t got);
    bit found = 0;
    got = '0;
    for (int i = 0; i < budget && !found; i++) begin
      sendSlot('0);
      if (memOpmOut[7:6] == 2'b01) begin
        found = 1;
        got   = dutOut();
      end
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL %s: no response within %0d cycles", name, budget);
    end
  endtask

  slot_t r;
  slot_t pass;
  slot_t hitB;
  int    base;

  initial begin
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset ring", 256'(dutOut()), 256'(0));
    check("reset mmio", 256'({mmioAddr, mmioOpm, mmioOutData}), 256'(0));
    reset = 1'b1;

    // Pass-through of a non-MMIO load.
    pass = mkSlot(48'h00001000, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 16'h0080, 16'h1203);
    sendSlot(pass);
    check("pass slot", 256'(dutOut()), 256'(pass));
    check("pass mmioOpm", 256'(mmioOpm), 256'(0));

    // MMIO load.
    respDelay = 3; respCode = 2'b01; respData = 64'h1122334455667788;
    sendSlot(mkSlot(48'hF0001000, 128'h0, 16'h0083, 16'h4205));
    check("load accept slot", 256'(dutOut()), 256'(0));
    check("load mmioAddr", 256'(mmioAddr), 256'(32'hF0001000));
    check("load mmioOpm", 256'(mmioOpm), 256'(5'h0B));
    waitResp(20, "load response", r);
    check("load resp opm", 256'(r.opm), 256'(16'h0043));
    check("load resp seq", 256'(r.seq), 256'(16'h4205));
    check("load resp data", 256'(r.data), 256'(128'h1122334455667788));
    check("load resp addr", 256'(r.addr), 256'(48'hF0001000));

    // MMIO store; only data[63:0] is written.
    sendSlot(mkSlot(48'hF0000010, 128'hAAAA_BBBB_CCCC_DDDD_0000_0000_DEAD_BEEF, 16'h00C2, 16'h0107));
    check("store mmioOpm", 256'(mmioOpm), 256'(5'h12));
    check("store mmioOutData", 256'(mmioOutData), 256'(64'hDEADBEEF));
    waitResp(20, "store response", r);
    check("store resp opm", 256'(r.opm), 256'(16'h0042));
    check("store resp data", 256'(r.data), 256'(0));

    // Busy bounce and deferred injection.
    respData = 64'h0000_0000_CAFE_F00D;
    sendSlot(mkSlot(48'hF0000100, 128'h0, 16'h0081, 16'h3001));
    hitB = mkSlot(48'hF0002000, 128'h55, 16'h0081, 16'h3002);
    sendSlot(hitB);
    check("bounced hit", 256'(dutOut()), 256'(hitB));
    base = respCount;
    for (int i = 0; i < 10; i++)
      sendSlot(mkSlot(48'h00002000 + 48'(i), 128'(i), 16'h0001, 16'h5000 + 16'(i)));
    check("no inject into occupied", 256'(respCount - base), 256'(0));
    sendSlot('0);
    check("deferred resp seq", 256'(memSeqOut), 256'(16'h3001));
    check("deferred resp opm", 256'(memOpmOut), 256'(16'h0041));
    check("deferred resp data", 256'(memDataOut), 256'(128'hCAFEF00D));
    sendSlot('0);
    check("single inject", 256'(memOpmOut), 256'(0));

    // Fault status.
    respDelay = 1; respCode = 2'b11;
    sendSlot(mkSlot(48'hF0000200, 128'h0, 16'h0083, 16'h6001));
    waitResp(20, "fault response", r);
    check("fault resp opm", 256'(r.opm), 256'(16'h007F));
    check("fault resp data", 256'(r.data), 256'(0));

    // Timeout in both ACCESS and RELEASE.
    respCode = 2'b10; releaseBusy = 1;
    sendSlot(mkSlot(48'hF0000300, 128'h0, 16'h0081, 16'h7001));
    waitResp(3 * TIMEOUT, "timeout response", r);
    check("timeout resp opm", 256'(r.opm), 256'(16'h007F));
    check("timeout resp seq", 256'(r.seq), 256'(16'h7001));
    releaseBusy = 0;
    repeat (2) sendSlot('0);

    // Reset mid-access.
    respDelay = 50; respCode = 2'b01;
    sendSlot(mkSlot(48'hF0000400, 128'h0, 16'h0083, 16'h8001));
    repeat (2) sendSlot('0);
    #2 reset = 1'b0;
    #1;
    check("mid reset ring", 256'(dutOut()), 256'(0));
    check("mid reset mmio", 256'({mmioAddr, mmioOpm, mmioOutData}), 256'(0));
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    base = respCount;
    sendSlot(pass);
    check("post reset pass", 256'(dutOut()), 256'(pass));
    repeat (20) sendSlot('0);
    check("no stray response", 256'(respCount - base), 256'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rbi_l2_mmio_bridge.md
Name: rbi_l2_mmio_bridge

Overview:
- Ring-bus node that bridges L2 ring memory requests in the MMIO address window onto a simple 64-bit MMIO port.
- Sits on the L2 ring between the ROM node and the ring return path.
- Forwards all other traffic unchanged with one cycle of latency.
- Executes at most one MMIO access at a time and injects its response into an empty ring slot.

Parameters:
- MMIO_TIMEOUT, 4095, cycles to wait for MMIO completion before returning a fault response.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- memAddrIn  in  48  ring slot address in.
- memAddrOut  out  48  ring slot address out.
- memDataIn  in  128  ring slot data (tile) in.
- memDataOut  out  128  ring slot data out.
- memOpmIn  in  16  ring slot operation mode in.
- memOpmOut  out  16  ring slot operation mode out.
- memSeqIn  in  16  ring slot sequence in: [15:8] source node, [7:0] tag.
- memSeqOut  out  16  ring slot sequence out.
- unitNodeId  in  8  this node's ID; informational, not used for decode.
- mmioAddr  out  32  MMIO address.
- mmioOpm  out  5  MMIO op: [4:3] 00 idle, 01 read, 10 write; [2:0] size.
- mmioInData  in  64  MMIO read data.
- mmioOutData  out  64  MMIO write data.
- mmioOK  in  2  MMIO status: 00 ready, 01 done, 10 busy/hold, 11 fault.

Behaviour:
- Opm[7:0] slot classes:
  - 0 = empty slot.
  - [7:6] 01 = response.
  - [7:6] 10 = load request.
  - [7:6] 11 = store request.
  - Anything else is passed through.
- MMIO hit condition: request class, memAddrIn[47:32]==0 and memAddrIn[31:28]==4'hF.
- Ring outputs are registered. Every cycle the input slot is copied to the outputs at the next edge, except in the two cases below.
- Accept: in IDLE, a hit is consumed.
  - Latch addr, opm, seq and data[63:0].
  - Output slot is emptied: opm=0, seq=0, addr=0, data=0.
  - Go to ACCESS.
- Busy: hits arriving in any state other than IDLE pass through unchanged; the requester retries when the slot comes around again.
- FSM IDLE -> ACCESS -> RELEASE -> RESPOND -> IDLE.
- ACCESS:
  - mmioAddr = latched addr[31:0].
  - mmioOpm = {01 for load / 10 for store, opm[2:0]}.
  - mmioOutData = latched data[63:0].
  - Hold these until mmioOK is 01 or 11.
  - On 01: capture mmioInData (load) and set fault=0.
  - On 11: set fault=1.
  - In both cases go to RELEASE.
  - mmioOK 00 or 10 keeps waiting.
  - A timeout counter reaching MMIO_TIMEOUT sets fault=1 and goes to RELEASE.
- RELEASE:
  - mmioOpm=0.
  - Wait for mmioOK==00, then go to RESPOND.
  - The timeout counter restarts on entering RELEASE. If it reaches MMIO_TIMEOUT, go to RESPOND anyway; fault stays as set.
- RESPOND: on the first cycle the input slot is empty (memOpmIn[7:0]==0), inject the response there.
  - opm = {latched opm[15:8], 2'b01, fault ? 6'h3F : latched opm[5:0]}.
  - seq = latched seq.
  - addr = latched addr.
  - data = {64'h0, read data}; a store or fault returns data 0.
  - Then go to IDLE.
  - A non-empty slot passes through, and the response waits.
- The node never drops or reorders non-hit traffic. A hit can only be consumed in IDLE, so accept and inject never occur in the same cycle.
- Reset (async, active low):
  - All ring outputs 0.
  - mmioAddr, mmioOpm, mmioOutData 0.
  - FSM IDLE; counters and latches cleared.
  - Reset mid-access abandons the access without a response.

Test Plan:
- Pass-through: opm=0x0080, addr=0x00001000, seq=0x1203, data=X -> identical slot on outputs one cycle later; mmioOpm stays 0.
- MMIO load:
  - Stimulus: opm=0x0083, addr=0xF0001000, seq=0x4205, then empty slots; mmioOK=01 with mmioInData=0x1122334455667788 after 3 cycles, then 00.
  - Required during access: mmioAddr=0xF0001000 and mmioOpm=0x0B; the accepting cycle's output slot is empty.
  - Required response: opm=0x0043, seq=0x4205, data low 64 = 0x1122334455667788.
- MMIO store: opm=0x00C2, data=0xDEADBEEF, addr=0xF0000010; mmioOK=01 -> mmioOpm=0x12, mmioOutData=0xDEADBEEF; response opm=0x0042, data=0.
- Busy bounce: a second hit arrives while in ACCESS -> it passes through unchanged. Response injection deferred behind occupied slots -> injected on the first empty slot only.
- Fault/timeout: mmioOK=11 -> response opm[5:0]=0x3F. mmioOK held at 10 for MMIO_TIMEOUT cycles -> fault response.
- Reset asserted during ACCESS -> all outputs 0 immediately; after release, pass-through resumes with no stray response.
